slot_game_ctrl: RTL and testbench

Parametrised game controller for the slot-machine design: tracks credit, starts a spin on request, stops an arbitrary number of reels in any order, evaluates the stopped reel values and applies a saturating payout. It sits between the debounced button/coin pulses and the reel counters, 7-segment and LCD drivers. It adds the following over the fixed three-reel controller:

- configurable reel count and digit width;
- per-spin bet deduction;
- cash-out;
- coin rejection at full credit;
- an auto-stop timeout.

---
 rtl/slot_pkg.sv | 29 ++
 rtl/slot_match_eval.sv | 30 +++
 rtl/slot_game_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_slot_game_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// slot_pkg: shared state encoding, payout classes and saturating add for the slot game.
`default_nettype none

package slot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CREDIT = 3'd1,
    ST_SPIN   = 3'd2,
    ST_EVAL   = 3'd3,
    ST_PAY    = 3'd4,
    ST_LOCK   = 3'd5
  } state_e;

  localparam logic [1:0] PAY_CLS_NONE = 2'd0;
  localparam logic [1:0] PAY_CLS_PAIR = 2'd1;
  localparam logic [1:0] PAY_CLS_ALL  = 2'd2;

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/slot_match_eval.sv
// slot_match_eval: pairwise compare of the reel snapshot, flags all-equal and any-pair.
`default_nettype none

module slot_match_eval #(
  parameter int NUM_REELS = 3,
  parameter int DIGIT_W   = 4
) (
  input  logic [NUM_REELS*DIGIT_W-1:0] snap_i,
  output logic                         all_eq_o,
  output logic                         any_pair_o
);

  // All-equal holds exactly when every pair compares equal.
  always_comb begin
    all_eq_o   = 1'b1;
    any_pair_o = 1'b0;
    for (int i = 0; i < NUM_REELS; i++) begin
      for (int j = i + 1; j < NUM_REELS; j++) begin
        if (snap_i[i*DIGIT_W +: DIGIT_W] == snap_i[j*DIGIT_W +: DIGIT_W]) begin
          any_pair_o = 1'b1;
        end else begin
          all_eq_o = 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/slot_game_ctrl.sv
// slot_game_ctrl: credit tracking, spin/stop sequencing, auto-stop, evaluation and payout.
`default_nettype none

module slot_game_ctrl
  import slot_pkg::*;
#(
  parameter int NUM_REELS     = 3,
  parameter int DIGIT_W       = 4,
  parameter int CREDIT_W      = 7,
  parameter int CREDIT_MAX    = 99,
  parameter int BET           = 1,
  parameter int PAY_ALL       = 10,
  parameter int PAY_PAIR      = 5,
  parameter int PAY_NONE      = 1,
  parameter int AUTO_STOP_CYC = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         coin_in_i,
  input  logic                         start_i,
  input  logic                         cash_out_i,
  input  logic [NUM_REELS-1:0]         stop_btn_i,
  input  logic [NUM_REELS*DIGIT_W-1:0] reel_val_i,
  output logic [NUM_REELS-1:0]         reel_run_o,
  output logic [CREDIT_W-1:0]          credit_o,
  output logic [2:0]                   state_o,
  output logic                         led_en_o,
  output logic                         win_pulse_o,
  output logic [CREDIT_W-1:0]          win_amt_o,
  output logic                         coin_rej_o,
  output logic                         game_over_o
);

  localparam int TW = $clog2(AUTO_STOP_CYC + 1);
  localparam int DW = NUM_REELS * DIGIT_W;

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d, win_amt_q, win_amt_d;
  logic [NUM_REELS-1:0]  run_q, run_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DW-1:0]         snap_q, snap_d;
  logic                  win_pulse_q, win_pulse_d, coin_rej_q, coin_rej_d;
  logic                  led_en_q, game_over_q;
  logic                  all_eq, any_pair;
  logic [NUM_REELS-1:0]  valid_stop, lowest_run;
  logic [1:0]            pay_cls;
  logic [CREDIT_W-1:0]   payout;
  logic [31:0]           coin_w;

  function automatic logic [CREDIT_W-1:0] sat_credit(input logic [31:0] a, input logic [31:0] b);
    return CREDIT_W'(sat_add(a, b, 32'(CREDIT_MAX)));
  endfunction

  // Reels are already frozen during EVAL, so the live value is the snapshot.
  assign snap_d = (state_q == ST_EVAL) ? reel_val_i : snap_q;

  slot_match_eval #(
    .NUM_REELS (NUM_REELS),
    .DIGIT_W   (DIGIT_W)
  ) u_match (
    .snap_i     (snap_d),
    .all_eq_o   (all_eq),
    .any_pair_o (any_pair)
  );

  assign pay_cls    = all_eq ? PAY_CLS_ALL : (any_pair ? PAY_CLS_PAIR : PAY_CLS_NONE);
  assign valid_stop = stop_btn_i & run_q;
  assign lowest_run = run_q & (~run_q + NUM_REELS'(1));
  assign coin_w     = {31'd0, coin_in_i};

  always_comb begin
    case (pay_cls)
      PAY_CLS_ALL:  payout = CREDIT_W'(PAY_ALL);
      PAY_CLS_PAIR: payout = CREDIT_W'(PAY_PAIR);
      default:      payout = CREDIT_W'(PAY_NONE);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    run_d       = run_q;
    timer_d     = timer_q;
    win_amt_d   = win_amt_q;
    win_pulse_d = 1'b0;
    coin_rej_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (coin_in_i) begin
          credit_d = CREDIT_W'(1);
          state_d  = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        if (cash_out_i) begin
          credit_d = '0;
          state_d  = ST_IDLE;
        end else if (start_i && (32'(credit_q) >= 32'(BET))) begin
          credit_d = sat_credit(32'(credit_q) - 32'(BET), coin_w);
          run_d    = '1;
          timer_d  = '0;
          state_d  = ST_SPIN;
        end else if (coin_in_i) begin
          if (32'(credit_q) == 32'(CREDIT_MAX)) coin_rej_d = 1'b1;
          else                                  credit_d   = credit_q + CREDIT_W'(1);
        end
      end
      ST_SPIN: begin
        credit_d = sat_credit(32'(credit_q), coin_w);
        if (|valid_stop) begin
          run_d   = run_q & ~valid_stop;
          timer_d = '0;
        end else if (timer_q == TW'(AUTO_STOP_CYC - 1)) begin
          run_d   = run_q & ~lowest_run;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
        if (run_d == '0) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        credit_d    = sat_credit(32'(credit_q), coin_w);
        win_amt_d   = payout;
        win_pulse_d = 1'b1;
        state_d     = ST_PAY;
      end
      ST_PAY: begin
        credit_d = sat_credit(32'(credit_q), 32'(win_amt_q) + coin_w);
        if (32'(credit_d) == 32'(CREDIT_MAX)) state_d = ST_LOCK;
        else if (credit_d == '0)              state_d = ST_IDLE;
        else                                  state_d = ST_CREDIT;
      end
      ST_LOCK: begin
        if (cash_out_i) begin
          credit_d = '0;
          state_d  = ST_IDLE;
        end else if (coin_in_i) begin
          coin_rej_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      credit_q    <= '0;
      run_q       <= '0;
      timer_q     <= '0;
      snap_q      <= '0;
      win_amt_q   <= '0;
      win_pulse_q <= 1'b0;
      coin_rej_q  <= 1'b0;
      led_en_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      run_q       <= run_d;
      timer_q     <= timer_d;
      snap_q      <= snap_d;
      win_amt_q   <= win_amt_d;
      win_pulse_q <= win_pulse_d;
      coin_rej_q  <= coin_rej_d;
      led_en_q    <= (state_d == ST_SPIN);
      game_over_q <= (state_d == ST_LOCK);
    end
  end

  assign reel_run_o  = run_q;
  assign credit_o    = credit_q;
  assign state_o     = state_q;
  assign led_en_o    = led_en_q;
  assign win_pulse_o = win_pulse_q;
  assign win_amt_o   = win_amt_q;
  assign coin_rej_o  = coin_rej_q;
  assign game_over_o = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_slot_game_ctrl.sv
// tb_slot_game_ctrl: directed scenarios with hand-computed expectations for slot_game_ctrl.
`default_nettype none

module tb_slot_game_ctrl;

  localparam int NR = 3;
  localparam int DW = 4;
  localparam int CW = 7;

  localparam logic [2:0] S_IDLE = 3'd0, S_CREDIT = 3'd1, S_SPIN = 3'd2,
                         S_EVAL = 3'd3, S_PAY = 3'd4, S_LOCK = 3'd5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              coin_in = 1'b0, start = 1'b0, cash_out = 1'b0;
  logic [NR-1:0]     stop_btn = '0;
  logic [NR*DW-1:0]  reel_val = '0;
  logic [NR-1:0]     reel_run;
  logic [CW-1:0]     credit, win_amt;
  logic [2:0]        state;
  logic              led_en, win_pulse, coin_rej, game_over;

  int errors = 0;
  int checks = 0;

  slot_game_ctrl #(
    .NUM_REELS     (NR),
    .DIGIT_W       (DW),
    .CREDIT_W      (CW),
    .CREDIT_MAX    (99),
    .BET           (1),
    .PAY_ALL       (10),
    .PAY_PAIR      (5),
    .PAY_NONE      (1),
    .AUTO_STOP_CYC (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin_in_i   (coin_in),
    .start_i     (start),
    .cash_out_i  (cash_out),
    .stop_btn_i  (stop_btn),
    .reel_val_i  (reel_val),
    .reel_run_o  (reel_run),
    .credit_o    (credit),
    .state_o     (state),
    .led_en_o    (led_en),
    .win_pulse_o (win_pulse),
    .win_amt_o   (win_amt),
    .coin_rej_o  (coin_rej),
    .game_over_o (game_over)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_coin();
    coin_in = 1'b1; step(1); coin_in = 1'b0;
  endtask

  task automatic do_cash();
    cash_out = 1'b1; step(1); cash_out = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic do_stop(input logic [NR-1:0] m);
    stop_btn = m; step(1); stop_btn = '0;
  endtask

  initial begin
    step(3);
    check_eq("rst_credit", credit, 0);
    check_eq("rst_state", state, S_IDLE);
    check_eq("rst_reel_run", reel_run, 0);
    check_eq("rst_win_amt", win_amt, 0);
    rst_n = 1'b1;
    step(1);

    // coins and cash-out
    do_coin(); check_eq("coin1", credit, 1); check_eq("coin1_state", state, S_CREDIT);
    do_coin(); check_eq("coin2", credit, 2);
    do_coin(); check_eq("coin3", credit, 3);
    do_cash(); check_eq("cash_credit", credit, 0); check_eq("cash_state", state, S_IDLE);

    // jackpot: stops 2, 0, 1
    do_coin(); do_coin();
    reel_val = {4'd7, 4'd7, 4'd7};
    do_start();
    check_eq("jp_spin_state", state, S_SPIN);
    check_eq("jp_spin_credit", credit, 1);
    check_eq("jp_run_all", reel_run, 3'b111);
    check_eq("jp_led", led_en, 1);
    do_stop(3'b100); check_eq("jp_stop2", reel_run, 3'b011);
    do_stop(3'b100); check_eq("jp_restop2", reel_run, 3'b011);
    do_stop(3'b001); check_eq("jp_stop0", reel_run, 3'b010);
    do_stop(3'b010); check_eq("jp_stop1", reel_run, 3'b000);
    check_eq("jp_eval", state, S_EVAL);
    check_eq("jp_no_pulse_eval", win_pulse, 0);
    step(1);
    check_eq("jp_pay_state", state, S_PAY);
    check_eq("jp_pulse", win_pulse, 1);
    check_eq("jp_amt", win_amt, 10);
    step(1);
    check_eq("jp_credit", credit, 11);
    check_eq("jp_back_credit", state, S_CREDIT);
    check_eq("jp_pulse_off", win_pulse, 0);
    check_eq("jp_amt_held", win_amt, 10);

    // pair, then no match
    reel_val = {4'd3, 4'd5, 4'd3};
    do_start(); check_eq("pair_bet", credit, 10);
    do_stop(3'b111); check_eq("pair_eval", state, S_EVAL);
    step(1); check_eq("pair_amt", win_amt, 5);
    step(1); check_eq("pair_credit", credit, 15);
    reel_val = {4'd4, 4'd2, 4'd1};
    do_start(); check_eq("none_bet", credit, 14);
    do_stop(3'b111);
    step(1); check_eq("none_amt", win_amt, 1);
    step(1); check_eq("none_credit", credit, 15);

    // saturation and lock
    do_cash();
    for (int i = 0; i < 95; i++) do_coin();
    check_eq("preload", credit, 95);
    reel_val = {4'd7, 4'd7, 4'd7};
    do_start(); check_eq("sat_bet", credit, 94);
    do_stop(3'b111);
    step(1); check_eq("sat_amt", win_amt, 10);
    step(1);
    check_eq("sat_credit", credit, 99);
    check_eq("sat_lock", state, S_LOCK);
    check_eq("sat_game_over", game_over, 1);
    do_coin();
    check_eq("lock_rej", coin_rej, 1);
    check_eq("lock_credit", credit, 99);
    step(1); check_eq("lock_rej_off", coin_rej, 0);
    do_cash();
    check_eq("lock_cash_state", state, S_IDLE);
    check_eq("lock_cash_credit", credit, 0);
    check_eq("lock_go_off", game_over, 0);

    // auto-stop
    reel_val = {4'd4, 4'd2, 4'd1};
    do_coin();
    do_start(); check_eq("as_credit", credit, 0);
    step(7); check_eq("as_hold0", reel_run, 3'b111);
    step(1); check_eq("as_drop0", reel_run, 3'b110);
    step(7); check_eq("as_hold1", reel_run, 3'b110);
    step(1); check_eq("as_drop1", reel_run, 3'b100);
    step(7); check_eq("as_hold2", reel_run, 3'b100);
    step(1); check_eq("as_drop2", reel_run, 3'b000);
    check_eq("as_eval", state, S_EVAL);
    step(1); check_eq("as_amt", win_amt, 1);
    step(1);
    check_eq("as_credit_after", credit, 1);
    check_eq("as_state_after", state, S_CREDIT);

    // reset mid-spin
    do_coin();
    do_start(); check_eq("rs_spin", state, S_SPIN);
    step(2);
    rst_n = 1'b0;
    #1;
    check_eq("rs_reel_run", reel_run, 0);
    check_eq("rs_credit", credit, 0);
    check_eq("rs_win_amt", win_amt, 0);
    check_eq("rs_state", state, S_IDLE);
    check_eq("rs_led", led_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
